// File: rtl/ser_rx_pkg.sv
// Shared types and constants for the serial receive front end.
// Used by ser_shift8 and ser_byte_framer_50.
package ser_rx_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] HDR_TEMP_DEF  = 8'hA5;
    localparam logic [BYTE_W-1:0] HDR_CHECK_DEF = 8'hC3;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } framer_state_t;

    // True when data bits plus the trailing parity bit hold an even number of ones.
    function automatic logic even_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

endpackage

// File: rtl/ser_shift8.sv
// 8-bit MSB-first deserialiser with a saturating count of valid bits seen.
// The fill count tells the framer when the window holds eight fresh bits.
module ser_shift8
    import ser_rx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              line_valid,
    input  logic              fill_clr,
    output logic [BYTE_W-1:0] next_word,
    output logic [3:0]        fill_cnt
);

    logic [BYTE_W-1:0] shift_reg;

    // The window as it will look once the current bit has been shifted in.
    assign next_word = {shift_reg[BYTE_W-2:0], serial_in};

    // Shift on every valid bit; the fill count restarts on gaps or on request and stops at 8.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            fill_cnt  <= 4'd0;
        end else begin
            if (line_valid) begin
                shift_reg <= next_word;
            end
            if (!line_valid || fill_clr) begin
                fill_cnt <= 4'd0;
            end else if (fill_cnt != 4'd8) begin
                fill_cnt <= fill_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ser_byte_framer_50.sv
// Serial byte framer for the 50 MHz receive path.
// Hunts bit-by-bit for a header byte, then frames PKT_BYTES payload bytes,
// strobing each byte downstream and flagging headers with a5_or_c3.
// Optional build macro SER_PARITY_CHK_EN: each payload byte carries a trailing
// even-parity bit, and a bad parity bit aborts the packet instead of strobing.
module ser_byte_framer_50
    import ser_rx_pkg::*;
#(
    parameter int                PKT_BYTES = 4,
    parameter logic [BYTE_W-1:0] HDR_TEMP  = HDR_TEMP_DEF,
    parameter logic [BYTE_W-1:0] HDR_CHECK = HDR_CHECK_DEF
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              line_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_strb,
    output logic              a5_or_c3,
    output logic              data_ena,
    output logic              pkt_abort
);

    localparam logic [3:0] LAST_BYTE = 4'(PKT_BYTES - 1);
`ifdef SER_PARITY_CHK_EN
    localparam logic [3:0] LAST_BIT  = 4'd8;
`else
    localparam logic [3:0] LAST_BIT  = 4'd7;
`endif

    framer_state_t     state;
    logic [3:0]        bit_cnt;
    logic [3:0]        byte_cnt;
    logic [BYTE_W-1:0] next_word;
    logic [3:0]        fill_cnt;
    logic              fill_clr;
    logic              hdr_hit;
    logic [BYTE_W-1:0] assembled;
    logic              par_ok;

    // Keeping the fill count at zero throughout a packet means the next header needs eight fresh bits.
    assign fill_clr = (state == PAYLOAD);

    assign hdr_hit = line_valid && (fill_cnt >= 4'd7) &&
                     ((next_word == HDR_TEMP) || (next_word == HDR_CHECK));

`ifdef SER_PARITY_CHK_EN
    logic [BYTE_W-1:0] data_hold;

    assign assembled = data_hold;
    assign par_ok    = even_parity_ok(data_hold, serial_in);

    // Capture the eight data bits so they survive the parity bit being shifted in.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            data_hold <= '0;
        end else if (state == PAYLOAD && line_valid && bit_cnt == 4'd7) begin
            data_hold <= next_word;
        end
    end
`else
    assign assembled = next_word;
    assign par_ok    = 1'b1;
`endif

    ser_shift8 u_shift (
        .clk        (clk_50),
        .reset      (reset),
        .serial_in  (serial_in),
        .line_valid (line_valid),
        .fill_clr   (fill_clr),
        .next_word  (next_word),
        .fill_cnt   (fill_cnt)
    );

    // Header hunt and payload framing; every output is a register updated here.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state     <= HUNT;
            bit_cnt   <= 4'd0;
            byte_cnt  <= 4'd0;
            byte_out  <= '0;
            byte_strb <= 1'b0;
            a5_or_c3  <= 1'b0;
            data_ena  <= 1'b0;
            pkt_abort <= 1'b0;
        end else begin
            byte_strb <= 1'b0;
            a5_or_c3  <= 1'b0;
            pkt_abort <= 1'b0;
            case (state)
                HUNT: begin
                    data_ena <= 1'b0;
                    if (hdr_hit) begin
                        byte_out  <= next_word;
                        byte_strb <= 1'b1;
                        a5_or_c3  <= 1'b1;
                        data_ena  <= 1'b1;
                        bit_cnt   <= 4'd0;
                        byte_cnt  <= 4'd0;
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!line_valid) begin
                        pkt_abort <= 1'b1;
                        data_ena  <= 1'b0;
                        bit_cnt   <= 4'd0;
                        state     <= HUNT;
                    end else if (bit_cnt != LAST_BIT) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else begin
                        bit_cnt <= 4'd0;
                        if (!par_ok) begin
                            pkt_abort <= 1'b1;
                            data_ena  <= 1'b0;
                            state     <= HUNT;
                        end else begin
                            byte_out  <= assembled;
                            byte_strb <= 1'b1;
                            byte_cnt  <= byte_cnt + 4'd1;
                            if (byte_cnt == LAST_BYTE) begin
                                state <= HUNT;
                            end
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_byte_framer_50.sv
// Directed self-checking bench for ser_byte_framer_50 (default PKT_BYTES=4).
// Also exercises the parity feature when built with SER_PARITY_CHK_EN.
module tb_ser_byte_framer_50;

`ifdef SER_PARITY_CHK_EN
    localparam bit PAR      = 1'b1;
    localparam int STRB_POS = 8;
`else
    localparam bit PAR      = 1'b0;
    localparam int STRB_POS = 7;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic       line_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_strb;
    logic       a5_or_c3;
    logic       data_ena;
    logic       pkt_abort;

    int vectors = 0;
    int miscompares = 0;

    ser_byte_framer_50 dut (
        .clk_50     (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .line_valid (line_valid),
        .byte_out   (byte_out),
        .byte_strb  (byte_strb),
        .a5_or_c3   (a5_or_c3),
        .data_ena   (data_ena),
        .pkt_abort  (pkt_abort)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Drive one bit on the falling edge, return just after the following rising edge.
    task automatic send_bit(input logic b, input logic v);
        @(negedge clk);
        serial_in  = b;
        line_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Send a byte MSB first (plus optional parity bit), recording what strobed.
    task automatic send_byte(input logic [7:0] b, input bit add_par, input bit par,
                             output int nstrb, output int pos, output int na5);
        nstrb = 0;
        pos   = -1;
        na5   = 0;
        for (int i = 0; i < 8; i++) begin
            send_bit(b[7-i], 1'b1);
            if (byte_strb === 1'b1) begin
                nstrb++;
                pos = i;
                if (a5_or_c3 === 1'b1) na5++;
            end
        end
        if (add_par) begin
            send_bit(par, 1'b1);
            if (byte_strb === 1'b1) begin
                nstrb++;
                pos = 8;
                if (a5_or_c3 === 1'b1) na5++;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] prefix;
        int         nstrb;
        prefix = 7'b1010010;
        reset = 1'b1;
        line_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 6; i >= 0; i--) send_bit(prefix[i], 1'b1);
        reset = 1'b1;
        line_valid = 1'b1;
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (byte_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_byte_out: got %h want 00", byte_out); end
        vectors++;
        if (byte_strb !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_byte_strb: got %b want 0", byte_strb); end
        vectors++;
        if (a5_or_c3 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a5_or_c3: got %b want 0", a5_or_c3); end
        vectors++;
        if (data_ena !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data_ena: got %b want 0", data_ena); end
        vectors++;
        if (pkt_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pkt_abort: got %b want 0", pkt_abort); end
        reset = 1'b0;
        nstrb = 0;
        for (int i = 6; i >= 0; i--) begin
            send_bit(prefix[i], 1'b1);
            if (byte_strb === 1'b1) nstrb++;
        end
        vectors++;
        if (nstrb != 0) begin miscompares++; $display("[TB] FAIL reset_hunt_7bits: got %0d strobes want 0", nstrb); end
        send_bit(1'b1, 1'b1);
        vectors++;
        if ({byte_strb, a5_or_c3, data_ena, byte_out} !== {3'b111, 8'hA5})
            begin miscompares++; $display("[TB] FAIL reset_first_hdr: got %b%b%b/%h want 111/a5", byte_strb, a5_or_c3, data_ena, byte_out); end
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
        reset = 1'b1;
        line_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({pkt_abort, data_ena, byte_strb} !== 3'b000)
            begin miscompares++; $display("[TB] FAIL reset_mid_pkt: got abort/ena/strb %b want 000", {pkt_abort, data_ena, byte_strb}); end
        vectors++;
        if (byte_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_mid_pkt_byte: got %h want 00", byte_out); end
        reset = 1'b0;
    endtask

    task automatic test_temp_packet();
        logic [7:0] pay [4];
        int nstrb, pos, na5, pre;
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        pre = 0;
        send_bit(1'b0, 1'b1);
        if (byte_strb === 1'b1) pre++;
        send_bit(1'b1, 1'b1);
        if (byte_strb === 1'b1) pre++;
        send_byte(8'hA5, 1'b0, 1'b0, nstrb, pos, na5);
        vectors++;
        if (nstrb != 1 || pos != 7 || pre != 0)
            begin miscompares++; $display("[TB] FAIL temp_hdr_strb: got %0d/%0d at %0d want 0/1 at 7", pre, nstrb, pos); end
        vectors++;
        if ({a5_or_c3, data_ena, byte_out} !== {2'b11, 8'hA5})
            begin miscompares++; $display("[TB] FAIL temp_hdr_out: got %b%b/%h want 11/a5", a5_or_c3, data_ena, byte_out); end
        for (int k = 0; k < 4; k++) begin
            send_byte(pay[k], PAR, ^pay[k], nstrb, pos, na5);
            vectors++;
            if (nstrb != 1 || pos != STRB_POS || na5 != 0)
                begin miscompares++; $display("[TB] FAIL temp_pay%0d_strb: got n=%0d pos=%0d hdr=%0d want 1/%0d/0", k, nstrb, pos, na5, STRB_POS); end
            vectors++;
            if ({data_ena, pkt_abort, byte_out} !== {2'b10, pay[k]})
                begin miscompares++; $display("[TB] FAIL temp_pay%0d_out: got ena/abort %b%b byte %h want 10 %h", k, data_ena, pkt_abort, byte_out, pay[k]); end
        end
        send_bit(1'b0, 1'b0);
        vectors++;
        if ({data_ena, pkt_abort, byte_strb} !== 3'b000)
            begin miscompares++; $display("[TB] FAIL temp_end: got ena/abort/strb %b want 000", {data_ena, pkt_abort, byte_strb}); end
    endtask

    task automatic test_check_packet();
        logic [7:0] pay [4];
        int nstrb, pos, na5;
        pay = '{8'hA5, 8'hC3, 8'h00, 8'hFF};
        send_byte(8'hC3, 1'b0, 1'b0, nstrb, pos, na5);
        vectors++;
        if (nstrb != 1 || pos != 7 || na5 != 1 || byte_out !== 8'hC3 || data_ena !== 1'b1)
            begin miscompares++; $display("[TB] FAIL check_hdr: got n=%0d pos=%0d hdr=%0d byte %h ena %b want 1/7/1 c3 1", nstrb, pos, na5, byte_out, data_ena); end
        for (int k = 0; k < 4; k++) begin
            send_byte(pay[k], PAR, ^pay[k], nstrb, pos, na5);
            vectors++;
            if (nstrb != 1 || na5 != 0 || byte_out !== pay[k])
                begin miscompares++; $display("[TB] FAIL check_pay%0d: got n=%0d hdr=%0d byte %h want 1/0 %h", k, nstrb, na5, byte_out, pay[k]); end
        end
        send_bit(1'b0, 1'b0);
        vectors++;
        if (data_ena !== 1'b0) begin miscompares++; $display("[TB] FAIL check_end: got data_ena %b want 0", data_ena); end
    endtask

    task automatic test_abort();
        logic [4:0] tail;
        int nstrb, pos, na5, ntail;
        tail = 5'b10110;
        send_byte(8'hA5, 1'b0, 1'b0, nstrb, pos, na5);
        vectors++;
        if (nstrb != 1 || na5 != 1) begin miscompares++; $display("[TB] FAIL abort_hdr: got n=%0d hdr=%0d want 1/1", nstrb, na5); end
        send_byte(8'h5A, PAR, ^8'h5A, nstrb, pos, na5);
        vectors++;
        if (nstrb != 1 || byte_out !== 8'h5A) begin miscompares++; $display("[TB] FAIL abort_pay0: got n=%0d byte %h want 1 5a", nstrb, byte_out); end
        ntail = 0;
        for (int i = 4; i >= 0; i--) begin
            send_bit(tail[i], 1'b1);
            if (byte_strb === 1'b1) ntail++;
        end
        send_bit(1'b0, 1'b0);
        vectors++;
        if ({pkt_abort, data_ena, byte_strb} !== 3'b100 || ntail != 0)
            begin miscompares++; $display("[TB] FAIL abort_pulse: got abort/ena/strb %b tail strobes %0d want 100 0", {pkt_abort, data_ena, byte_strb}, ntail); end
        vectors++;
        if (byte_out !== 8'h5A) begin miscompares++; $display("[TB] FAIL abort_hold: got %h want 5a", byte_out); end
        send_bit(1'b0, 1'b0);
        vectors++;
        if (pkt_abort !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_one_cycle: got %b want 0", pkt_abort); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pay [4];
        int nstrb, pos, na5;
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_byte(8'hA5, 1'b0, 1'b0, nstrb, pos, na5);
        for (int k = 0; k < 4; k++) send_byte(pay[k], PAR, ^pay[k], nstrb, pos, na5);
        vectors++;
        if (nstrb != 1 || byte_out !== 8'h44) begin miscompares++; $display("[TB] FAIL b2b_first_last: got n=%0d byte %h want 1 44", nstrb, byte_out); end
        send_byte(8'hC3, 1'b0, 1'b0, nstrb, pos, na5);
        vectors++;
        if (nstrb != 1 || pos != 7 || na5 != 1 || byte_out !== 8'hC3 || data_ena !== 1'b1)
            begin miscompares++; $display("[TB] FAIL b2b_second_hdr: got n=%0d pos=%0d hdr=%0d byte %h ena %b want 1/7/1 c3 1", nstrb, pos, na5, byte_out, data_ena); end
        for (int k = 0; k < 4; k++) begin
            send_byte(pay[3-k], PAR, ^pay[3-k], nstrb, pos, na5);
            vectors++;
            if (nstrb != 1 || na5 != 0 || byte_out !== pay[3-k])
                begin miscompares++; $display("[TB] FAIL b2b_pay%0d: got n=%0d hdr=%0d byte %h want 1/0 %h", k, nstrb, na5, byte_out, pay[3-k]); end
        end
        send_bit(1'b0, 1'b0);
        vectors++;
        if (data_ena !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_end: got data_ena %b want 0", data_ena); end
    endtask

`ifdef SER_PARITY_CHK_EN
    task automatic test_parity();
        int nstrb, pos, na5;
        send_byte(8'hA5, 1'b0, 1'b0, nstrb, pos, na5);
        send_byte(8'h07, 1'b1, 1'b0, nstrb, pos, na5);
        vectors++;
        if (nstrb != 0 || pkt_abort !== 1'b1 || data_ena !== 1'b0)
            begin miscompares++; $display("[TB] FAIL parity_bad: got n=%0d abort %b ena %b want 0 1 0", nstrb, pkt_abort, data_ena); end
        send_bit(1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0, nstrb, pos, na5);
        send_byte(8'h07, 1'b1, 1'b1, nstrb, pos, na5);
        vectors++;
        if (nstrb != 1 || pos != 8 || byte_out !== 8'h07 || pkt_abort !== 1'b0)
            begin miscompares++; $display("[TB] FAIL parity_good: got n=%0d pos=%0d byte %h abort %b want 1/8 07 0", nstrb, pos, byte_out, pkt_abort); end
        for (int k = 0; k < 3; k++) send_byte(8'h10, 1'b1, 1'b1, nstrb, pos, na5);
        send_bit(1'b0, 1'b0);
        vectors++;
        if (data_ena !== 1'b0 || byte_out !== 8'h10)
            begin miscompares++; $display("[TB] FAIL parity_end: got ena %b byte %h want 0 10", data_ena, byte_out); end
    endtask
`endif

    // Watchdog so the run always ends even if a wait goes wrong.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_temp_packet();
        test_check_packet();
        test_abort();
        test_back_to_back();
`ifdef SER_PARITY_CHK_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
